dma_copy_ctrl: RTL and testbench
================================

Name: dma_copy_ctrl

Overview:
- AFU-side controller that drives the DMA read and write channels of the CCI DMA engine.
- Launches a read/write pair from software-supplied addresses and size.
- Moves each cacheline from the DMA read FIFO to the DMA write port through one registered stage, optionally transforming the data.
- Reports completion once both channels report done.

Parameters:
- ADDR_WIDTH, 64, byte virtual address width.
- SIZE_WIDTH, 43, cacheline count width (cacheline address width + 1).
- DATA_WIDTH, 512, cacheline width in bits.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- go  in  1  start pulse; ignored unless in IDLE or DONE.
- rd_addr  in  ADDR_WIDTH  source byte address, 64 B aligned.
- wr_addr  in  ADDR_WIDTH  destination byte address, 64 B aligned.
- size  in  SIZE_WIDTH  cachelines to copy.
- busy  out  1  high in START, SETTLE, RUN.
- done  out  1  sticky completion; cleared by an accepted go.
- xfer_count  out  SIZE_WIDTH  cachelines written this job.
- dma_rd_go, dma_wr_go  out  1  one-cycle start pulses.
- dma_rd_addr, dma_wr_addr  out  ADDR_WIDTH  registered copies of rd_addr/wr_addr.
- dma_rd_size, dma_wr_size  out  SIZE_WIDTH  registered copy of size.
- dma_rd_done, dma_wr_done  in  1  channel idle.
- dma_empty  in  1  read FIFO empty.
- dma_rd_en  out  1  read FIFO pop.
- dma_rd_data  in  DATA_WIDTH  first-word-fall-through; valid whenever dma_empty=0.
- dma_full  in  1  write back-pressure.
- dma_wr_en  out  1  write request.
- dma_wr_data  out  DATA_WIDTH  write data.

Behaviour:
- Reset values: all outputs 0, state IDLE, pipe_valid 0.
- FSM states and transitions:
  - IDLE –go→ START. On this edge, latch addresses and size, clear xfer_count, clear done.
  - START: assert dma_rd_go and dma_wr_go for exactly one cycle; →SETTLE.
  - SETTLE: one cycle, covering the registered done/remaining update inside the DMA; →RUN.
  - RUN: stays until dma_rd_done && dma_wr_done && !pipe_valid; then →DONE with done=1.
  - DONE –go→ START, with the same latching as from IDLE.
  - go in START, SETTLE or RUN is ignored.
- Datapath: a single stage holding pipe_valid and pipe_data.
  - Pop when dma_rd_en = !dma_empty && (!pipe_valid || !dma_full); the pop loads pipe_data next cycle.
  - dma_wr_en = pipe_valid && !dma_full, combinational. A write is accepted on dma_wr_en. xfer_count increments on each accepted write.
  - Simultaneous pop and write keeps pipe_valid=1, giving one cacheline per cycle sustained.
  - pipe_valid clears only on a write with no pop.
- The datapath runs in every state; the DMA itself limits the data to size lines.
- Latency: FIFO head to dma_wr_en is 1 cycle.
- dma_full held high: pipe stalls, dma_rd_en=0 while pipe_valid, data held stable.
- size=0: go pulses issued, DMA stays done, done asserts 3 cycles after go (START, SETTLE, RUN).
- xfer_count wraps modulo 2^SIZE_WIDTH; not reachable in practice.
- Reset mid-job: immediate return to IDLE, pipe data discarded. The DMA engine shares the reset.

Optional Feature:
- Macro DMA_COPY_XFORM_EN.
  - Defined: pipe_data = each 32-bit lane of dma_rd_data plus 1, modulo 2^32, lane-wise with no carry between lanes.
  - Undefined: pure pass-through.
- Latency and handshake are identical in both builds.

Decomposition:
- Package dma_copy_pkg: state enum {IDLE, START, SETTLE, RUN, DONE}, CL_BYTES=64, LANE_WIDTH=32.
- Sub-module dma_copy_xform: a combinational lane transform, selected by the macro, instanced inside the single pipe stage.

Test Plan:
- size=4, rd_addr=0x1000, wr_addr=0x2000, model FIFO preloaded with 4 lines, dma_full=0:
  - dma_rd_go/dma_wr_go pulse one cycle after go, dma_*_addr/size captured.
  - 4 consecutive dma_wr_en, data equal to input (or lanes +1 with the macro).
  - xfer_count=4, done=1.
- size=8, dma_full toggled high for 3 cycles mid-stream: no write lost or duplicated, order preserved, xfer_count=8.
- size=0: done=1 on the 3rd cycle after go; no dma_wr_en or dma_rd_en.
- go asserted during RUN: no extra dma_*_go, latched size unchanged, job completes normally.
- rst_n low in RUN with pipe_valid=1: outputs 0 asynchronously. After release, go with size=2 completes with xfer_count=2.
- DMA_COPY_XFORM_EN, lane value 0xFFFFFFFF: output lane 0x00000000, neighbouring lane unaffected.

Source files
------------

// File: rtl/dma_copy_pkg.sv
// dma_copy_pkg: shared FSM state type and constants for the DMA copy controller
package dma_copy_pkg;
  typedef enum logic [2:0] {IDLE, START, SETTLE, RUN, DONE} state_t;
  localparam int CL_BYTES   = 64;
  localparam int LANE_WIDTH = 32;
endpackage

// File: rtl/dma_copy_xform.sv
// dma_copy_xform: combinational cacheline transform in the pipe stage (macro DMA_COPY_XFORM_EN)
//   din  : cacheline popped from the read FIFO
//   dout : DMA_COPY_XFORM_EN defined -> each 32-bit lane + 1 (no inter-lane carry); else din
module dma_copy_xform import dma_copy_pkg::*; #(
  parameter int DATA_WIDTH = 512
) (
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);
`ifdef DMA_COPY_XFORM_EN
  for (genvar i = 0; i < DATA_WIDTH / LANE_WIDTH; i++) begin : g_lane
    assign dout[i*LANE_WIDTH +: LANE_WIDTH] = din[i*LANE_WIDTH +: LANE_WIDTH] + LANE_WIDTH'(1);
  end
`else
  assign dout = din;
`endif
endmodule

// File: rtl/dma_copy_ctrl.sv
// dma_copy_ctrl: launches a DMA read/write pair and streams lines from read FIFO to write port
//   go/rd_addr/wr_addr/size : job request, accepted only in IDLE or DONE
//   busy/done/xfer_count    : job status (done sticky until next accepted go)
//   dma_rd_go/dma_wr_go, dma_*_addr, dma_*_size : channel launch
//   dma_rd_done/dma_wr_done : channel idle; dma_empty/dma_rd_en/dma_rd_data : FWFT read FIFO
//   dma_full/dma_wr_en/dma_wr_data : write port
//   Optional macro DMA_COPY_XFORM_EN selects the lane +1 transform in the pipe stage.
module dma_copy_ctrl import dma_copy_pkg::*; #(
  parameter int ADDR_WIDTH = 64,
  parameter int SIZE_WIDTH = 43,
  parameter int DATA_WIDTH = 512
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  go,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [SIZE_WIDTH-1:0] size,
  output logic                  busy,
  output logic                  done,
  output logic [SIZE_WIDTH-1:0] xfer_count,
  output logic                  dma_rd_go,
  output logic                  dma_wr_go,
  output logic [ADDR_WIDTH-1:0] dma_rd_addr,
  output logic [ADDR_WIDTH-1:0] dma_wr_addr,
  output logic [SIZE_WIDTH-1:0] dma_rd_size,
  output logic [SIZE_WIDTH-1:0] dma_wr_size,
  input  logic                  dma_rd_done,
  input  logic                  dma_wr_done,
  input  logic                  dma_empty,
  output logic                  dma_rd_en,
  input  logic [DATA_WIDTH-1:0] dma_rd_data,
  input  logic                  dma_full,
  output logic                  dma_wr_en,
  output logic [DATA_WIDTH-1:0] dma_wr_data
);
  state_t state, state_nxt;
  logic pipe_valid, accept;
  logic [DATA_WIDTH-1:0] pipe_data, xf_data;
  assign accept = go && (state == IDLE || state == DONE);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    dma_rd_go = 1'b0;
    dma_wr_go = 1'b0;
    case (state)
      IDLE:    state_nxt = go ? START : IDLE;
      START:   begin state_nxt = SETTLE; busy = 1'b1; dma_rd_go = 1'b1; dma_wr_go = 1'b1; end
      SETTLE:  begin state_nxt = RUN; busy = 1'b1; end
      RUN:     begin state_nxt = (dma_rd_done && dma_wr_done && !pipe_valid) ? DONE : RUN; busy = 1'b1; end
      DONE:    begin state_nxt = go ? START : DONE; done = 1'b1; end
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      dma_rd_addr <= '0;
      dma_wr_addr <= '0;
      dma_rd_size <= '0;
      dma_wr_size <= '0;
      xfer_count  <= '0;
    end else if (accept) begin
      dma_rd_addr <= rd_addr;
      dma_wr_addr <= wr_addr;
      dma_rd_size <= size;
      dma_wr_size <= size;
      xfer_count  <= '0;
    end else if (dma_wr_en) xfer_count <= xfer_count + SIZE_WIDTH'(1);
  // A pop refills the stage even while it drains, sustaining one line per cycle.
  assign dma_rd_en   = !dma_empty && (!pipe_valid || !dma_full);
  assign dma_wr_en   = pipe_valid && !dma_full;
  assign dma_wr_data = pipe_data;
  dma_copy_xform #(.DATA_WIDTH(DATA_WIDTH)) u_xform (.din(dma_rd_data), .dout(xf_data));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pipe_valid <= 1'b0;
      pipe_data  <= '0;
    end else begin
      if (dma_rd_en) pipe_data <= xf_data;
      pipe_valid <= dma_rd_en || (pipe_valid && !dma_wr_en);
    end
endmodule

// File: tb/tb_dma_copy_ctrl.sv
// tb_dma_copy_ctrl: randomized bench with a queue-based DMA channel model and scoreboard
module tb_dma_copy_ctrl;
  localparam int AW = 64, SW = 43, DW = 512;
  logic clk = 0, rst_n = 0, go = 0;
  logic [AW-1:0] rd_addr = '0, wr_addr = '0;
  logic [SW-1:0] size = '0;
  logic busy, done, dma_rd_go, dma_wr_go, dma_rd_en, dma_wr_en;
  logic [SW-1:0] xfer_count, dma_rd_size, dma_wr_size;
  logic [AW-1:0] dma_rd_addr, dma_wr_addr;
  logic [DW-1:0] dma_wr_data;
  logic dma_rd_done = 1, dma_wr_done = 1, dma_empty = 1, dma_full = 0;
  logic [DW-1:0] dma_rd_data = '0;

  dma_copy_ctrl dut (
    .clk(clk), .rst_n(rst_n), .go(go), .rd_addr(rd_addr), .wr_addr(wr_addr), .size(size),
    .busy(busy), .done(done), .xfer_count(xfer_count), .dma_rd_go(dma_rd_go), .dma_wr_go(dma_wr_go),
    .dma_rd_addr(dma_rd_addr), .dma_wr_addr(dma_wr_addr), .dma_rd_size(dma_rd_size),
    .dma_wr_size(dma_wr_size), .dma_rd_done(dma_rd_done), .dma_wr_done(dma_wr_done),
    .dma_empty(dma_empty), .dma_rd_en(dma_rd_en), .dma_rd_data(dma_rd_data), .dma_full(dma_full),
    .dma_wr_en(dma_wr_en), .dma_wr_data(dma_wr_data)
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_err = 0;
  int cyc = 0, rd_go_cnt = 0, wr_go_cnt = 0, pop_cnt = 0, wr_cnt = 0;
  int full_mode = 0;
  bit gap_en = 0;
  logic [DW-1:0] src_q[$], fifo_q[$], exp_q[$], wr_log[$];
  int pop_cyc[$], wr_cyc[$];
  longint wr_rem = 0;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] xf(input logic [DW-1:0] d);
    logic [DW-1:0] r = d;
`ifdef DMA_COPY_XFORM_EN
    for (int k = 0; k < DW / 32; k++) r[32*k +: 32] = d[32*k +: 32] + 32'd1;
`endif
    return r;
  endfunction

  function automatic logic [DW-1:0] rand_line();
    logic [DW-1:0] r;
    for (int k = 0; k < DW / 32; k++) r[32*k +: 32] = $urandom;
    return r;
  endfunction

  task automatic flush();
    fifo_q.delete();
    exp_q.delete();
    wr_rem = 0;
    dma_empty = 1;
    dma_rd_data = '0;
    dma_rd_done = 1;
    dma_wr_done = 1;
  endtask

  // DMA channel model: samples handshakes at negedge, updates FIFO/status just after posedge.
  initial begin
    logic s_rst, s_rd_en, s_wr_en, s_rd_go, s_wr_go;
    logic [SW-1:0] s_rd_size, s_wr_size;
    bit avail;
    forever begin
      @(negedge clk);
      cyc++;
      s_rst = rst_n; s_rd_en = dma_rd_en; s_wr_en = dma_wr_en;
      s_rd_go = dma_rd_go; s_wr_go = dma_wr_go; s_rd_size = dma_rd_size; s_wr_size = dma_wr_size;
      if (s_rst) begin
        if (s_rd_go) rd_go_cnt++;
        if (s_wr_go) wr_go_cnt++;
        if (s_rd_en) begin pop_cnt++; pop_cyc.push_back(cyc); end
        if (s_wr_en) begin
          wr_cnt++;
          wr_cyc.push_back(cyc);
          wr_log.push_back(dma_wr_data);
          if (exp_q.size() == 0) check("wr_extra", 1, 0);
          else check("wr_data", dma_wr_data, exp_q.pop_front());
        end
      end
      @(posedge clk);
      #1;
      if (!rst_n || !s_rst) flush();
      else begin
        if (s_rd_en && fifo_q.size() > 0) void'(fifo_q.pop_front());
        if (s_wr_en && wr_rem > 0) wr_rem--;
        if (s_rd_go)
          for (int i = 0; i < int'(s_rd_size); i++) begin
            logic [DW-1:0] l;
            l = src_q.size() > 0 ? src_q.pop_front() : rand_line();
            fifo_q.push_back(l);
            exp_q.push_back(xf(l));
          end
        if (s_wr_go) wr_rem = longint'(s_wr_size);
        avail = !gap_en || $urandom_range(0, 3) != 0;
        dma_full = full_mode == 2 ? $urandom_range(0, 2) == 0 : full_mode == 1;
        dma_empty = fifo_q.size() == 0 || !avail;
        dma_rd_data = fifo_q.size() > 0 ? fifo_q[0] : '0;
        dma_rd_done = fifo_q.size() == 0;
        dma_wr_done = wr_rem == 0;
      end
    end
  end

  task automatic start_job(input logic [AW-1:0] ra, input logic [AW-1:0] wa, input logic [SW-1:0] n);
    @(negedge clk);
    rd_addr = ra; wr_addr = wa; size = n; go = 1;
    @(negedge clk);
    go = 0;
    check("rd_go", dma_rd_go, 1);
    check("wr_go", dma_wr_go, 1);
    check("rd_addr", dma_rd_addr, ra);
    check("wr_addr", dma_wr_addr, wa);
    check("rd_size", dma_rd_size, n);
    check("wr_size", dma_wr_size, n);
    check("busy_start", busy, 1);
    check("done_clr", done, 0);
    check("xfer_clr", xfer_count, 0);
    @(negedge clk);
    check("go_one_cycle", dma_rd_go | dma_wr_go, 0);
    check("done_settle", done, 0);
  endtask

  task automatic wait_done(input int n);
    for (int i = 0; i < 400 && !done; i++) @(negedge clk);
    check("done", done, 1);
    check("busy_idle", busy, 0);
    check("xfer_count", xfer_count, n);
    check("exp_left", exp_q.size(), 0);
  endtask

  task automatic check_reset_outputs();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_xfer", xfer_count, 0);
    check("rst_go", dma_rd_go | dma_wr_go, 0);
    check("rst_addr", dma_rd_addr | dma_wr_addr, 0);
    check("rst_size", dma_rd_size | dma_wr_size, 0);
    check("rst_rd_en", dma_rd_en, 0);
    check("rst_wr_en", dma_wr_en, 0);
    check("rst_wr_data", dma_wr_data, 0);
  endtask

  initial begin
    logic [DW-1:0] held, l0;
    int g0, w0, p0, c0;
    flush();
    repeat (3) @(negedge clk);
    check_reset_outputs();
    rst_n = 1;

    // Basic 4-line job; first line exercises the lane wrap boundary.
    l0 = rand_line();
    l0[63:0] = 64'h12345678_FFFFFFFF;
    src_q.push_back(l0);
    for (int i = 0; i < 3; i++) src_q.push_back(rand_line());
    wr_log.delete(); wr_cyc.delete(); pop_cyc.delete();
    start_job(64'h1000, 64'h2000, 4);
    wait_done(4);
    check("wr_n", wr_log.size(), 4);
    if (wr_cyc.size() == 4 && pop_cyc.size() > 0) begin
      check("wr_back2back", wr_cyc[3] - wr_cyc[0], 3);
      check("head_to_wr", wr_cyc[0] - pop_cyc[0], 1);
`ifdef DMA_COPY_XFORM_EN
      check("lane0_wrap", wr_log[0][31:0], 32'h00000000);
      check("lane1", wr_log[0][63:32], 32'h12345679);
`else
      check("lane0_pass", wr_log[0][31:0], 32'hFFFFFFFF);
      check("lane1", wr_log[0][63:32], 32'h12345678);
`endif
    end

    // 8 lines with a 3-cycle write stall mid-stream.
    wr_log.delete();
    start_job(64'h4000, 64'h8000, 8);
    for (int i = 0; i < 50 && wr_log.size() < 3; i++) @(negedge clk);
    full_mode = 1;
    @(negedge clk);
    held = dma_wr_data;
    for (int i = 0; i < 3; i++) begin
      check("stall_wr_en", dma_wr_en, 0);
      check("stall_rd_en", dma_rd_en, 0);
      check("stall_data", dma_wr_data, held);
      @(negedge clk);
    end
    full_mode = 0;
    wait_done(8);

    // Zero-length job.
    p0 = pop_cnt; w0 = wr_cnt;
    start_job(64'h40, 64'h80, 0);
    @(negedge clk);
    check("zero_done_run", done, 0);
    check("zero_busy_run", busy, 1);
    @(negedge clk);
    check("zero_done", done, 1);
    check("zero_pops", pop_cnt - p0, 0);
    check("zero_wrs", wr_cnt - w0, 0);

    // go during RUN is ignored.
    full_mode = 2; gap_en = 1;
    start_job(64'hC0, 64'h100, 6);
    @(negedge clk);
    g0 = rd_go_cnt; c0 = wr_go_cnt;
    size = 3; go = 1;
    @(negedge clk);
    go = 0;
    @(negedge clk);
    check("run_go_rd", rd_go_cnt - g0, 0);
    check("run_go_wr", wr_go_cnt - c0, 0);
    check("run_size", dma_rd_size, 6);
    check("run_busy", busy, 1);
    wait_done(6);

    // Asynchronous reset mid-job with the stage held full.
    full_mode = 0; gap_en = 0;
    start_job(64'h10000, 64'h20000, 10);
    @(negedge clk);
    full_mode = 1;
    repeat (2) @(negedge clk);
    #2 rst_n = 0;
    flush();
    #1 check_reset_outputs();
    @(negedge clk);
    rst_n = 1;
    full_mode = 0;
    start_job(64'h3000, 64'h5000, 2);
    wait_done(2);

    // Randomized jobs with gaps and random back-pressure.
    full_mode = 2; gap_en = 1;
    for (int j = 0; j < 6; j++) begin
      logic [AW-1:0] ra, wa;
      int n;
      ra = {$urandom, $urandom} & ~64'h3F;
      wa = {$urandom, $urandom} & ~64'h3F;
      n = $urandom_range(1, 16);
      start_job(ra, wa, SW'(n));
      wait_done(n);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
